// File: rtl/spectrum_frame_buffer.sv
// ---------------------------------------------------------------------------
// spectrum_frame_buffer
//
// Collects the spectral filter's free-running complex sample stream into
// 32-sample frames, using a ping-pong pair of register banks. Each completed
// frame is replayed to the IFFT/output stage over a valid/ready handshake,
// optionally in un-bit-reversed order. The upstream side has no backpressure,
// so a sample that arrives while the target bank is still occupied is
// dropped, and the sticky overflow flag is raised.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_r/in_i  signed sample from the filter, qualified by in_valid
//   out_r/out_i  signed frame element presented to the consumer
//   out_index  output-order index k of the presented element
//   out_valid  element presented
//   out_ready  consumer accepts (transfer = out_valid & out_ready at an edge)
//   out_last   high with the element k = N-1
//   overflow   sticky: at least one input sample was dropped
// ---------------------------------------------------------------------------
module spectrum_frame_buffer #(
   parameter int WIDTH  = 16,
   parameter int LOGN   = 5,
   parameter int BITREV = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic signed [WIDTH-1:0] in_r,
   input  logic signed [WIDTH-1:0] in_i,
   input  logic                    in_valid,
   output logic signed [WIDTH-1:0] out_r,
   output logic signed [WIDTH-1:0] out_i,
   output logic [LOGN-1:0]         out_index,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_last,
   output logic                    overflow
);

   localparam int N = 2 ** LOGN;
   localparam logic [LOGN-1:0] KMAX = LOGN'(N - 1);

   typedef logic [2*WIDTH-1:0] word_t;
   typedef enum logic {IDLE, STREAM} state_t;

   // Storage is not reset: contents are only read once the bank's full flag
   // says a complete frame was written.
   word_t bank_q [2][N];

   logic [1:0]      full_q, full_d;
   logic            wr_bank_q;
   logic            rd_bank_q;
   logic [LOGN-1:0] wr_addr_q;
   logic            overflow_q;

   state_t                  state_q;
   logic signed [WIDTH-1:0] out_r_q, out_i_q;
   logic [LOGN-1:0]         out_index_q;
   logic                    out_valid_q, out_last_q;

   // Output-order index to storage address.
   function automatic logic [LOGN-1:0] addr_map(input logic [LOGN-1:0] k);
      logic [LOGN-1:0] r;
      for (int b = 0; b < LOGN; b++) r[b] = k[LOGN-1-b];
      return (BITREV != 0) ? r : k;
   endfunction

   logic            wr_en, wr_done;
   logic            xfer, rd_done;
   logic [LOGN-1:0] next_k, rd_k;
   word_t           rd_word;

   // Write is gated by the pre-edge full flag, so a sample landing on the
   // same edge the reader frees that bank is still dropped.
   assign wr_en   = in_valid && !full_q[wr_bank_q];
   assign wr_done = wr_en && (wr_addr_q == KMAX);

   assign xfer    = out_valid_q && out_ready;
   assign rd_done = xfer && (out_index_q == KMAX);

   // In IDLE the next element to present is k=0, otherwise k+1.
   assign next_k  = out_index_q + LOGN'(1);
   assign rd_k    = (state_q == IDLE) ? '0 : next_k;
   assign rd_word = bank_q[rd_bank_q][addr_map(rd_k)];

   // Completing bank A and freeing bank B may coincide; they never target
   // the same bank (the bank under read is full, so it cannot be written).
   always_comb begin
      full_d = full_q;
      if (wr_done) full_d[wr_bank_q] = 1'b1;
      if (rd_done) full_d[rd_bank_q] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (wr_en) bank_q[wr_bank_q][wr_addr_q] <= {in_r, in_i};
   end

   // Write-side control and sticky overflow.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         full_q     <= '0;
         wr_bank_q  <= 1'b0;
         wr_addr_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         full_q <= full_d;
         if (wr_en) begin
            wr_addr_q <= wr_addr_q + LOGN'(1);
            if (wr_done) wr_bank_q <= ~wr_bank_q;
         end
         if (in_valid && full_q[wr_bank_q]) overflow_q <= 1'b1;
      end
   end

   // Read FSM with registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         rd_bank_q   <= 1'b0;
         out_r_q     <= '0;
         out_i_q     <= '0;
         out_index_q <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (full_q[rd_bank_q]) begin
                  out_r_q     <= rd_word[2*WIDTH-1:WIDTH];
                  out_i_q     <= rd_word[WIDTH-1:0];
                  out_index_q <= '0;
                  out_last_q  <= 1'b0;
                  out_valid_q <= 1'b1;
                  state_q     <= STREAM;
               end
            end
            STREAM: begin
               if (xfer) begin
                  if (out_index_q == KMAX) begin
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                     rd_bank_q   <= ~rd_bank_q;
                     state_q     <= IDLE;
                  end else begin
                     out_r_q     <= rd_word[2*WIDTH-1:WIDTH];
                     out_i_q     <= rd_word[WIDTH-1:0];
                     out_index_q <= next_k;
                     out_last_q  <= (next_k == KMAX);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign out_r     = out_r_q;
   assign out_i     = out_i_q;
   assign out_index = out_index_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_spectrum_frame_buffer.sv
// ---------------------------------------------------------------------------
// Bench for spectrum_frame_buffer. Two instances (natural order and
// bit-reversed order) see identical stimulus. A frame-level reference model
// (queue of accepted samples, count of frames awaiting the reader) predicts
// drops, overflow and every presented element.
// ---------------------------------------------------------------------------
module tb_spectrum_frame_buffer;
   localparam int W = 16;
   localparam int LOGN = 5;
   localparam int N = 32;

   logic clk = 1'b0;
   logic reset;
   logic signed [W-1:0] in_r, in_i;
   logic in_valid, out_ready;

   logic signed [W-1:0] o_r [2];
   logic signed [W-1:0] o_i [2];
   logic [LOGN-1:0]     o_idx [2];
   logic                o_vld [2];
   logic                o_last [2];
   logic                ovf [2];

   spectrum_frame_buffer #(.WIDTH(W), .LOGN(LOGN), .BITREV(0)) u_nat (
      .clk(clk), .reset(reset), .in_r(in_r), .in_i(in_i), .in_valid(in_valid),
      .out_r(o_r[0]), .out_i(o_i[0]), .out_index(o_idx[0]), .out_valid(o_vld[0]),
      .out_ready(out_ready), .out_last(o_last[0]), .overflow(ovf[0]));

   spectrum_frame_buffer #(.WIDTH(W), .LOGN(LOGN), .BITREV(1)) u_rev (
      .clk(clk), .reset(reset), .in_r(in_r), .in_i(in_i), .in_valid(in_valid),
      .out_r(o_r[1]), .out_i(o_i[1]), .out_index(o_idx[1]), .out_valid(o_vld[1]),
      .out_ready(out_ready), .out_last(o_last[1]), .overflow(ovf[1]));

   always #5 clk = ~clk;

   // ---------------- reference model state ----------------
   logic [2*W-1:0] fq[$];    // completed frames awaiting / under read, in order
   logic [2*W-1:0] part[$];  // partial frame being collected
   int  pend;                // frames written but not yet fully read
   int  ek;                  // position of the presented element in head frame
   bit  ovf_m;
   int  frames_done;
   int  lowrun [2];
   int  cyc, last_cyc, cmpl_cyc, rise_cyc, gap_cyc;
   bit  vprev;

   int n_cmp = 0;
   int n_err = 0;

   function automatic int brev(input int k);
      int r = 0;
      for (int b = 0; b < LOGN; b++) if (((k >> b) & 1) != 0) r |= 1 << (LOGN - 1 - b);
      return r;
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_clear();
      fq.delete(); part.delete();
      pend = 0; ek = 0; ovf_m = 0; frames_done = 0;
      lowrun[0] = 0; lowrun[1] = 0;
      last_cyc = -1000; cmpl_cyc = -1000; rise_cyc = -1000; gap_cyc = -1000;
      vprev = 0;
   endtask

   // One clock: advance the model from the pre-edge inputs/handshake, clock,
   // then check the post-edge outputs against the model.
   task automatic step();
      bit drop_pre;
      drop_pre = (pend == 2);
      if (o_vld[0] && out_ready && fq.size() >= N) begin
         if (ek == N - 1) begin
            for (int j = 0; j < N; j++) void'(fq.pop_front());
            pend--; frames_done++; ek = 0; last_cyc = cyc + 1;
         end else ek++;
      end
      if (in_valid) begin
         if (drop_pre) ovf_m = 1;
         else begin
            part.push_back({in_r, in_i});
            if (part.size() == N) begin
               while (part.size() > 0) fq.push_back(part.pop_front());
               pend++; cmpl_cyc = cyc + 1;
            end
         end
      end
      vprev = o_vld[0];
      @(posedge clk); #1;
      cyc++;
      if (o_vld[0] && !vprev) begin
         rise_cyc = cyc; gap_cyc = cyc - last_cyc;
      end
      for (int u = 0; u < 2; u++) begin
         check($sformatf("overflow_dut%0d", u), ovf[u], ovf_m);
         if (o_vld[u]) begin
            lowrun[u] = 0;
            if (fq.size() < N) begin
               n_cmp++; n_err++;
               $display("FAIL valid_no_frame dut%0d: out_valid=1 required 0 (cycle %0d)", u, cyc);
            end else begin
               int a;
               a = (u == 1) ? brev(ek) : ek;
               check($sformatf("elem_dut%0d_k%0d", u, ek),
                     {26'b0, o_r[u], o_i[u], o_idx[u], o_last[u]},
                     {26'b0, fq[a], 5'(ek), (ek == N - 1)});
            end
         end else begin
            check($sformatf("last_idle_dut%0d", u), o_last[u], 0);
            if (pend > 0) begin
               lowrun[u]++;
               check($sformatf("valid_latency_dut%0d", u), (lowrun[u] < 2), 1);
            end else lowrun[u] = 0;
         end
      end
   endtask

   function automatic logic rv(input int mode);
      if (mode == 0) return 1'b1;
      if (mode == 1) return logic'($urandom_range(0, 1));
      return 1'b0;
   endfunction

   task automatic idle(input int mode);
      in_valid = 0; out_ready = rv(mode); step();
   endtask

   task automatic feed(input int nsamp, input int base, input int gap, input int mode, input bit rnd);
      for (int s = 0; s < nsamp; s++) begin
         if (gap == 2) while ($urandom_range(0, 3) == 0) idle(mode);
         in_valid  = 1;
         in_r      = rnd ? W'($urandom) : W'(base + s);
         in_i      = rnd ? W'($urandom) : W'(-(base + s));
         out_ready = rv(mode);
         step();
         if (gap == 1) idle(mode);
      end
      in_valid = 0;
   endtask

   task automatic drain();
      int g;
      g = 0;
      in_valid = 0; out_ready = 1;
      while ((fq.size() > 0 || o_vld[0]) && g < 400) begin step(); g++; end
      if (g >= 400) begin
         n_cmp++; n_err++;
         $display("FAIL drain_timeout: %0d frames left, required 0", fq.size() / N);
      end
   endtask

   task automatic do_reset();
      in_valid = 0; out_ready = 0; in_r = '0; in_i = '0;
      reset = 1;
      @(negedge clk);
      for (int u = 0; u < 2; u++)
         check($sformatf("reset_state_dut%0d", u),
               {26'b0, o_r[u], o_i[u], o_idx[u], o_vld[u], o_last[u], ovf[u]}, 64'd0);
      reset = 0;
      model_clear();
      step();
   endtask

   typedef struct {
      int nsamp; int base; int gap; int rdy; bit rnd; int exp_frames; int exp_ovf;
   } vec_t;

   vec_t tv[5];
   int   rev_tab[4];

   initial begin
      // gap: 0 contiguous, 1 every other cycle, 2 random; rdy: 0 high, 1 random,
      // 2 low while feeding. -1 means not checked at the end.
      tv[0] = '{32,  0, 0, 0, 1'b0,  1,  0};
      tv[1] = '{32,  0, 1, 0, 1'b0,  1,  0};
      tv[2] = '{32, 10, 0, 1, 1'b0,  1,  0};
      tv[3] = '{96,  0, 0, 2, 1'b0,  2,  1};
      tv[4] = '{200, 0, 2, 1, 1'b1, -1, -1};
      rev_tab = '{0, 16, 8, 24};
      cyc = 0;
      reset = 1; in_valid = 0; out_ready = 0; in_r = '0; in_i = '0;
      model_clear();
      #12;

      for (int t = 0; t < 5; t++) begin
         do_reset();
         feed(tv[t].nsamp, tv[t].base, tv[t].gap, tv[t].rdy, tv[t].rnd);
         drain();
         if (tv[t].exp_frames >= 0) check($sformatf("frames_v%0d", t), frames_done, tv[t].exp_frames);
         if (tv[t].exp_ovf >= 0)    check($sformatf("ovf_end_v%0d", t), ovf[0], tv[t].exp_ovf);
      end

      // Latency and bit-reversed order of the first elements.
      do_reset();
      feed(32, 0, 0, 0, 0);
      check("lat_lo", o_vld[0], 0);
      idle(0);
      check("lat_hi", o_vld[0], 1);
      check("lat_edges", rise_cyc - cmpl_cyc, 1);
      for (int j = 0; j < 4; j++) begin
         check($sformatf("nat_r_%0d", j), o_r[0], j);
         check($sformatf("rev_r_%0d", j), o_r[1], rev_tab[j]);
         idle(0);
      end
      drain();

      // Back-to-back frames: exactly one idle cycle between them.
      do_reset();
      feed(64, 0, 0, 0, 0);
      drain();
      check("b2b_frames", frames_done, 2);
      check("b2b_gap", gap_cyc, 1);

      // Asynchronous reset mid-cycle while a frame is presented and overflow set.
      do_reset();
      feed(96, 0, 0, 2, 0);
      feed(10, 200, 0, 2, 0);
      check("pre_rst_vld", o_vld[0], 1);
      check("pre_rst_ovf", ovf[0], 1);
      #2 reset = 1;
      #1;
      check("async_rst_vld", {o_vld[0], o_vld[1]}, 0);
      check("async_rst_ovf", {ovf[0], ovf[1]}, 0);
      @(negedge clk);
      reset = 0;
      model_clear();
      step();
      feed(32, 100, 0, 0, 0);
      idle(0);
      check("rst_first", o_r[0], 100);
      drain();
      check("rst_frames", frames_done, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/spectrum_frame_buffer.md
Name: spectrum_frame_buffer

Overview:
- Downstream stage of the post-FFT spectral filter. It consumes the filter's free-running complex sample stream (`out_r`/`out_i`, qualified by its `ready`).
- Collects 32-sample frames into a ping-pong pair of register banks. Each completed frame is re-emitted with a valid/ready handshake, optionally un-bit-reversed, for the IFFT/output stage.
- The upstream filter has no backpressure. The buffer decouples it from a stalling consumer and flags any samples it must drop.

Parameters:
- WIDTH, 16, bit width of each real/imag component (signed).
- LOGN, 5, log2 of frame length; N = 2**LOGN = 32.
- BITREV, 1, 1: output index k reads storage address bitrev(k); 0: natural order.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_r  input  WIDTH  signed real part from the filter.
- in_i  input  WIDTH  signed imaginary part from the filter.
- in_valid  input  1  sample qualifier (the filter's ready).
- out_r  output  WIDTH  signed real part of the frame element.
- out_i  output  WIDTH  signed imaginary part of the frame element.
- out_index  output  LOGN  output-order index k of the presented element.
- out_valid  output  1  element presented.
- out_ready  input  1  consumer accepts; a transfer occurs when out_valid and out_ready are both high at a clock edge.
- out_last  output  1  high with the element where k = N-1.
- overflow  output  1  sticky: at least one input sample was dropped.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - out_r, out_i, out_index, out_valid, out_last and overflow all go to 0.
  - wr_bank, rd_bank, wr_addr and both full flags clear; any partial frame is discarded.
  - Bank contents are don't-care.
- Storage: 2 banks × N × (2·WIDTH) flops, read combinationally. Each bank has a full flag.
- Write side:
  - At an edge with in_valid=1 and full[wr_bank]=0: store {in_r, in_i} at bank[wr_bank][wr_addr] and increment wr_addr.
  - On the write with wr_addr = N-1: set full[wr_bank], toggle wr_bank, wrap wr_addr to 0.
  - At an edge with in_valid=1 and full[wr_bank]=1: drop the sample, leave wr_addr unchanged, set overflow. overflow stays high until reset.
  - The full-flag check uses the pre-edge value. A sample arriving on the same edge that the reader frees that bank is still dropped.
  - Gaps in in_valid are allowed; a frame is any N accepted samples.
- Read FSM, states IDLE and STREAM:
  - IDLE: if full[rd_bank]=1 at an edge, load output registers with k=0, set out_valid=1, and go to STREAM.
    - Loaded values: out_r/out_i = bank[rd_bank][a(0)], out_index=0, out_last=0.
  - STREAM, transfer with k < N-1: load element k+1 at that edge. out_last=1 exactly when the new k = N-1.
  - STREAM, no transfer: out_r, out_i, out_index and out_last are held stable.
  - STREAM, transfer with k = N-1: clear full[rd_bank], toggle rd_bank, drop out_valid and out_last to 0, return to IDLE.
  - Address mapping a(k) = bitrev_LOGN(k) when BITREV=1, otherwise k.
- Latency and throughput:
  - If the last sample of a frame is written at edge E, out_valid is high after edge E+1.
  - With out_ready held high, N elements emit on consecutive cycles.
  - Back-to-back frames have exactly one idle cycle (out_valid=0) between out_last and the next k=0.
- Simultaneous events:
  - A write completing bank A and a read freeing bank B on the same edge both take effect.
  - A bank being read is never written, because its full flag is set.
- No arithmetic is performed; data passes bit-exact.

Test Plan:
- BITREV=0, out_ready=1, 32 samples in_r=k, in_i=-k on consecutive cycles → out_valid rises after edge E+1. Outputs are (0,0),(1,-1)…(31,-31) on consecutive cycles, out_last only at k=31, overflow=0.
- BITREV=1, same stimulus → out_r sequence 0,16,8,24,4,20,…,31 with out_index 0..31; a second frame follows after exactly one idle cycle.
- Backpressure: out_ready toggles pseudo-randomly during a frame → out_r, out_i and out_index are unchanged while out_valid=1 and out_ready=0. All 32 elements are delivered in order with none duplicated.
- Overflow: out_ready=0, feed 96 consecutive samples in_r=0..95 → overflow=1 from the edge of sample 64 onward. Then out_ready=1 drains in_r=0..31 then 32..63, and nothing from 64..95.
- Asynchronous reset asserted mid-cycle after 10 samples → out_valid and overflow go to 0 before the next edge. After release, 32 samples in_r=100+k emit starting at 100.
- in_valid asserted every other cycle for 32 samples → a single complete frame with the same ordering as the first scenario.
